q_cmac_acc: RTL and testbench

Q_CMAC_ACC -- requirements
Module: q_cmac_acc

---
 rtl/q_cmac_acc.sv | 195 +++++++++++++++++++
 tb/tb_q_cmac_acc.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/q_cmac_acc.sv
// rtl/q_cmac_acc.sv - pipelined complex multiply-accumulate with saturating dot-product result
module q_cmac_acc #(
  parameter int DATA_W = 16,
  parameter int FRAC   = 14,
  parameter int GUARD  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_a_re,
  input  logic signed [DATA_W-1:0] in_a_im,
  input  logic signed [DATA_W-1:0] in_b_re,
  input  logic signed [DATA_W-1:0] in_b_im,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_re,
  output logic signed [DATA_W-1:0] out_im,
  output logic                     out_ovf
);

  localparam int ACC_W  = DATA_W + GUARD;
  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = 2 * DATA_W + 1;
  // Wide enough to hold either a stage-2 value or an ACC_W+1 sum without wrapping
  localparam int WIDE_W = ((SUM_W > ACC_W) ? SUM_W : ACC_W) + 1;

  typedef enum logic [1:0] {ST_ACCUM, ST_DRAIN, ST_HOLD} state_t;

  state_t r_state, w_next_state;

  logic                      w_accept, w_load;
  logic                      r_s0_valid, r_s0_last;
  logic signed [DATA_W-1:0]  r_a_re, r_a_im, r_b_re, r_b_im;
  logic signed [PROD_W-1:0]  w_ar, w_ai, w_br, w_bi;
  logic                      r_s1_valid, r_s1_last;
  logic signed [PROD_W-1:0]  r_p_rr, r_p_ii, r_p_ri, r_p_ir;
  logic signed [SUM_W-1:0]   w_re_full, w_im_full;
  logic                      r_s2_valid, r_s2_last;
  logic signed [SUM_W-1:0]   r_s2_re, r_s2_im;
  logic [WIDE_W-1:0]         w_term_re_x, w_term_im_x, w_sum_re_x, w_sum_im_x;
  logic [ACC_W-1:0]          w_term_re, w_term_im, w_new_re, w_new_im;
  logic                      w_step_ovf, w_sat_ovf;
  logic [ACC_W-1:0]          r_acc_re, r_acc_im;
  logic                      r_sticky;
  logic [DATA_W-1:0]         r_out_re, r_out_im;
  logic                      r_out_ovf;

  // True when the value does not fit in ACC_W signed bits
  function automatic logic acc_ovf(input logic [WIDE_W-1:0] v);
    logic [WIDE_W-ACC_W:0] hi;
    hi = v[WIDE_W-1:ACC_W-1];
    return !((&hi) || !(|hi));
  endfunction

  function automatic logic [ACC_W-1:0] acc_clamp(input logic [WIDE_W-1:0] v);
    if (!acc_ovf(v)) return v[ACC_W-1:0];
    return v[WIDE_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  endfunction

  // True when an accumulator value does not fit in DATA_W signed bits
  function automatic logic out_sat(input logic [ACC_W-1:0] v);
    logic [ACC_W-DATA_W:0] hi;
    hi = v[ACC_W-1:DATA_W-1];
    return !((&hi) || !(|hi));
  endfunction

  function automatic logic [DATA_W-1:0] out_clamp(input logic [ACC_W-1:0] v);
    if (!out_sat(v)) return v[DATA_W-1:0];
    return v[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  assign w_accept = in_valid && in_ready;
  assign w_load   = r_s2_valid && r_s2_last;

  assign w_ar = {{DATA_W{r_a_re[DATA_W-1]}}, r_a_re};
  assign w_ai = {{DATA_W{r_a_im[DATA_W-1]}}, r_a_im};
  assign w_br = {{DATA_W{r_b_re[DATA_W-1]}}, r_b_re};
  assign w_bi = {{DATA_W{r_b_im[DATA_W-1]}}, r_b_im};

  assign w_re_full = {r_p_rr[PROD_W-1], r_p_rr} - {r_p_ii[PROD_W-1], r_p_ii};
  assign w_im_full = {r_p_ri[PROD_W-1], r_p_ri} + {r_p_ir[PROD_W-1], r_p_ir};

  assign w_term_re_x = {{(WIDE_W-SUM_W){r_s2_re[SUM_W-1]}}, r_s2_re};
  assign w_term_im_x = {{(WIDE_W-SUM_W){r_s2_im[SUM_W-1]}}, r_s2_im};
  assign w_term_re   = acc_clamp(w_term_re_x);
  assign w_term_im   = acc_clamp(w_term_im_x);
  assign w_sum_re_x  = {{(WIDE_W-ACC_W){r_acc_re[ACC_W-1]}}, r_acc_re}
                     + {{(WIDE_W-ACC_W){w_term_re[ACC_W-1]}}, w_term_re};
  assign w_sum_im_x  = {{(WIDE_W-ACC_W){r_acc_im[ACC_W-1]}}, r_acc_im}
                     + {{(WIDE_W-ACC_W){w_term_im[ACC_W-1]}}, w_term_im};
  assign w_new_re    = acc_clamp(w_sum_re_x);
  assign w_new_im    = acc_clamp(w_sum_im_x);
  assign w_step_ovf  = acc_ovf(w_term_re_x) | acc_ovf(w_term_im_x)
                     | acc_ovf(w_sum_re_x)  | acc_ovf(w_sum_im_x);
  assign w_sat_ovf   = out_sat(w_new_re) | out_sat(w_new_im);

  assign out_re  = r_out_re;
  assign out_im  = r_out_im;
  assign out_ovf = r_out_ovf;

  // Input capture: hold the accepted operands so the multipliers see registered data
  always_ff @(posedge clk) begin
    if (reset) r_s0_valid <= 1'b0;
    else       r_s0_valid <= w_accept;
    if (w_accept) begin
      r_a_re    <= in_a_re;
      r_a_im    <= in_a_im;
      r_b_re    <= in_b_re;
      r_b_im    <= in_b_im;
      r_s0_last <= in_last;
    end
  end

  // Stage 1: the four full-precision partial products
  always_ff @(posedge clk) begin
    if (reset) r_s1_valid <= 1'b0;
    else       r_s1_valid <= r_s0_valid;
    r_s1_last <= r_s0_last;
    r_p_rr    <= w_ar * w_br;
    r_p_ii    <= w_ai * w_bi;
    r_p_ri    <= w_ar * w_bi;
    r_p_ir    <= w_ai * w_br;
  end

  // Stage 2: combine products and drop fraction bits with floor rounding
  always_ff @(posedge clk) begin
    if (reset) r_s2_valid <= 1'b0;
    else       r_s2_valid <= r_s1_valid;
    r_s2_last <= r_s1_last;
    r_s2_re   <= w_re_full >>> FRAC;
    r_s2_im   <= w_im_full >>> FRAC;
  end

  // Stage 3: saturating accumulate; a last term empties the accumulators into the result
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc_re <= '0;
      r_acc_im <= '0;
      r_sticky <= 1'b0;
    end else if (r_s2_valid) begin
      if (r_s2_last) begin
        r_acc_re <= '0;
        r_acc_im <= '0;
        r_sticky <= 1'b0;
      end else begin
        r_acc_re <= w_new_re;
        r_acc_im <= w_new_im;
        r_sticky <= r_sticky | w_step_ovf;
      end
    end
  end

  // Result registers: loaded only by a last term, so they stay put while held
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_re  <= '0;
      r_out_im  <= '0;
      r_out_ovf <= 1'b0;
    end else if (w_load) begin
      r_out_re  <= out_clamp(w_new_re);
      r_out_im  <= out_clamp(w_new_im);
      r_out_ovf <= r_sticky | w_step_ovf | w_sat_ovf;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_ACCUM;
    else       r_state <= w_next_state;
  end

  // FSM next state and handshake outputs
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (w_accept && in_last) w_next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_load) w_next_state = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_next_state = ST_ACCUM;
      end
      default: w_next_state = ST_ACCUM;
    endcase
  end

endmodule

// File: tb/tb_q_cmac_acc.sv
// tb/tb_q_cmac_acc.sv - self-checking bench for q_cmac_acc
module tb_q_cmac_acc;

  localparam int DATA_W = 16;
  localparam int FRAC   = 14;
  localparam int GUARD  = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic in_last = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic out_ovf;
  logic signed [DATA_W-1:0] in_a_re = '0, in_a_im = '0, in_b_re = '0, in_b_im = '0;
  logic signed [DATA_W-1:0] out_re, out_im;

  typedef struct {
    int ar; int ai; int br; int bi;
    int last; int gap;
    int er; int ei; int eovf;
  } vec_t;

  typedef struct { int re; int im; int ovf; } res_t;

  vec_t vecs[$];
  res_t sb[$];
  int n_checks = 0;
  int n_fail = 0;

  q_cmac_acc #(.DATA_W(DATA_W), .FRAC(FRAC), .GUARD(GUARD)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a_re(in_a_re), .in_a_im(in_a_im), .in_b_re(in_b_re), .in_b_im(in_b_im),
    .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected test to finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_term(input int ar, input int ai, input int br, input int bi, input int last);
    int budget;
    budget = 0;
    in_a_re  = DATA_W'(ar);
    in_a_im  = DATA_W'(ai);
    in_b_re  = DATA_W'(br);
    in_b_im  = DATA_W'(bi);
    in_last  = (last != 0);
    in_valid = 1'b1;
    while (!in_ready && budget < 50) begin
      step();
      budget++;
    end
    if (budget >= 50) chk("accept_timeout", int'(in_ready), 1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (last != 0) chk("ready_low_after_last", int'(in_ready), 0);
  endtask

  task automatic wait_result(input string tag);
    int lat;
    int ready_seen;
    res_t e;
    lat = 0;
    ready_seen = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
      if (in_ready) ready_seen = 1;
    end
    chk({tag, "_latency"}, lat, 3);
    chk({tag, "_ready_low_in_drain"}, ready_seen, 0);
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_scoreboard: result with empty queue, expected a pending result", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_re"}, int'(out_re), e.re);
      chk({tag, "_im"}, int'(out_im), e.im);
      chk({tag, "_ovf"}, int'(out_ovf), e.ovf);
    end
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_valid_cleared"}, int'(out_valid), 0);
    chk({tag, "_ready_back"}, int'(in_ready), 1);
  endtask

  initial begin
    int quiet_valid;

    vecs.push_back('{16384, 0, 8192, -8192, 1, 0, 8192, -8192, 0});
    vecs.push_back('{0, 16384, 0, 16384, 1, 0, -16384, 0, 0});
    vecs.push_back('{0, 16384, 16384, 0, 1, 0, 0, 16384, 0});
    vecs.push_back('{11585, 0, 16384, 0, 0, 1, 0, 0, 0});
    vecs.push_back('{11585, 0, 16384, 0, 1, 0, 23170, 0, 0});
    vecs.push_back('{16384, 0, 16384, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{16384, 0, 16384, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{16384, 0, 16384, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{16384, 0, 16384, 0, 1, 0, 32767, 0, 1});
    vecs.push_back('{16384, 0, -16384, 0, 1, 0, -16384, 0, 0});
    vecs.push_back('{1, 0, -1, 0, 1, 0, -1, 0, 0});
    vecs.push_back('{-32768, 0, 32767, 0, 1, 0, -32768, 0, 1});
    vecs.push_back('{8192, 8192, 8192, 8192, 1, 0, 0, 8192, 0});

    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_re", int'(out_re), 0);
    chk("reset_out_im", int'(out_im), 0);
    chk("reset_out_ovf", int'(out_ovf), 0);
    chk("reset_in_ready", int'(in_ready), 1);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].last != 0) sb.push_back('{vecs[i].er, vecs[i].ei, vecs[i].eovf});
      send_term(vecs[i].ar, vecs[i].ai, vecs[i].br, vecs[i].bi, vecs[i].last);
      if (vecs[i].last != 0) begin
        wait_result($sformatf("vec%0d", i));
        consume($sformatf("vec%0d", i));
      end else begin
        repeat (vecs[i].gap) step();
      end
    end

    // Backpressure: out_ready high during drain must be ignored, then hold off for 5 cycles
    out_ready = 1'b1;
    sb.push_back('{8192, -8192, 0});
    send_term(16384, 0, 8192, -8192, 1);
    wait_result("bp");
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_valid_held", int'(out_valid), 1);
      chk("bp_ready_low", int'(in_ready), 0);
      chk("bp_re_stable", int'(out_re), 8192);
      chk("bp_im_stable", int'(out_im), -8192);
      chk("bp_ovf_stable", int'(out_ovf), 0);
    end
    consume("bp");

    // Reset one edge after the last term is accepted discards the dot product
    send_term(16384, 0, 16384, 0, 0);
    send_term(16384, 0, 16384, 0, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_ready", int'(in_ready), 1);
    quiet_valid = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (out_valid) quiet_valid = 1;
    end
    chk("midrst_no_output", quiet_valid, 0);
    sb.push_back('{100, 0, 0});
    send_term(16384, 0, 100, 0, 1);
    wait_result("midrst");
    consume("midrst");

    chk("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
